// File: rtl/mycpu_pkg.sv
// mycpu_pkg: definitions shared by the MEM stage of the 5-stage pipeline.
//   - Bus widths: EX2MEM_W, MEM2WB_W, MEM2ID_W
//   - Load-type codes (bit 2 set = zero-extend)
//   - Response-tracking states for an outstanding data-SRAM read
//   - Packed views of the EX->MEM, MEM->WB and MEM->ID buses
package mycpu_pkg;

    localparam int EX2MEM_W = 106;
    localparam int MEM2WB_W = 102;
    localparam int MEM2ID_W = 39;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b101;
    localparam logic [2:0] LD_HU = 3'b110;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_HOLD = 2'd2
    } resp_state_e;

    typedef struct packed {
        logic [2:0]  ld_type;
        logic        res_from_mem;
        logic [31:0] alu_result;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] inst;
    } ex2mem_t;

    typedef struct packed {
        logic [31:0] final_result;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] inst;
    } mem2wb_t;

    typedef struct packed {
        logic        wr_en;
        logic [4:0]  dest;
        logic [31:0] fwd_data;
        logic        load_pending;
    } mem2id_t;

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects and extends the loaded field out of a 32-bit read word.
// Ports:
//   rdata_i    in  32  raw word from the data SRAM (or its held copy)
//   off_i      in  2   byte offset, alu_result[1:0]
//   ld_type_i  in  3   load code from mycpu_pkg
//   result_o   out 32  aligned, sign/zero-extended load value
module mem_load_align
    import mycpu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  ld_type_i,
    output logic [31:0] result_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        case (off_i)
            2'd0:    byteSel = rdata_i[7:0];
            2'd1:    byteSel = rdata_i[15:8];
            2'd2:    byteSel = rdata_i[23:16];
            default: byteSel = rdata_i[31:24];
        endcase
    end

    // Halfword loads are aligned upstream, so only off[1] picks the half.
    assign halfSel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        case (ld_type_i)
            LD_B:    result_o = {{24{byteSel[7]}}, byteSel};
            LD_BU:   result_o = {24'b0, byteSel};
            LD_H:    result_o = {{16{halfSel[15]}}, halfSel};
            LD_HU:   result_o = {16'b0, halfSel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage in-order pipeline (between EX and WB).
// Holds one instruction, waits for the data-SRAM read response of a load,
// aligns the load data and drives the WB bus plus a hazard/forward bus to ID.
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   EX_to_MEM_valid/bus  incoming instruction (106 bits)
//   MEM_allow_in       MEM can take EX's bus this cycle
//   data_sram_data_ok  read response strobe, data_sram_rdata its data
//   WB_allow_in        WB can take MEM's result this cycle
//   MEM_to_WB_valid/bus  outgoing result (102 bits)
//   MEM_to_ID_bus      {wr_en, dest, fwd_data, load_pending} (39 bits)
// Build option: define MEM_FWD_EN to forward final_result on fwd_data;
// otherwise fwd_data is tied to zero and ID stalls on any dest match.
module mem_stage
    import mycpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                EX_to_MEM_valid,
    input  logic [EX2MEM_W-1:0] EX_to_MEM_bus,
    output logic                MEM_allow_in,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                WB_allow_in,
    output logic                MEM_to_WB_valid,
    output logic [MEM2WB_W-1:0] MEM_to_WB_bus,
    output logic [MEM2ID_W-1:0] MEM_to_ID_bus
);

    ex2mem_t     exBus;
    ex2mem_t     bus_q;
    logic        memValid_q;
    resp_state_e state_q;
    resp_state_e state_d;
    logic [31:0] rdataHold_q;
    logic [31:0] rdataHold_d;

    logic        readyGo;
    logic        accept;
    logic [31:0] loadSrc;
    logic [31:0] loadData;
    logic [31:0] finalResult;
    mem2wb_t     wbBus;
    mem2id_t     idBus;

    assign exBus = EX_to_MEM_bus;

    // A load may leave once its response is here now or was parked earlier.
    always_comb begin
        readyGo = 1'b1;
        if (bus_q.res_from_mem) begin
            readyGo = ((state_q == R_WAIT) && data_sram_data_ok) || (state_q == R_HOLD);
        end
    end

    assign MEM_allow_in    = ~memValid_q | (readyGo & WB_allow_in);
    assign accept          = EX_to_MEM_valid & MEM_allow_in;
    assign MEM_to_WB_valid = memValid_q & readyGo;

    // data_ok is only meaningful in R_WAIT; in R_IDLE or R_HOLD it is dropped,
    // so stale responses after reset and duplicate pulses never corrupt state.
    // A newly accepted instruction overrides the transition of the departing one.
    always_comb begin
        state_d     = state_q;
        rdataHold_d = rdataHold_q;
        case (state_q)
            R_WAIT: begin
                if (data_sram_data_ok) begin
                    if (WB_allow_in) begin
                        state_d = R_IDLE;
                    end else begin
                        state_d     = R_HOLD;
                        rdataHold_d = data_sram_rdata;
                    end
                end
            end
            R_HOLD: begin
                if (WB_allow_in) begin
                    state_d = R_IDLE;
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
        if (accept) begin
            state_d = exBus.res_from_mem ? R_WAIT : R_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memValid_q  <= 1'b0;
            state_q     <= R_IDLE;
            rdataHold_q <= 32'b0;
        end else begin
            if (MEM_allow_in) begin
                memValid_q <= EX_to_MEM_valid;
            end
            state_q     <= state_d;
            rdataHold_q <= rdataHold_d;
        end
    end

    // The payload is only meaningful while memValid_q is set, so it has no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            bus_q <= exBus;
        end
    end

    assign loadSrc = (state_q == R_HOLD) ? rdataHold_q : data_sram_rdata;

    mem_load_align u_align (
        .rdata_i   (loadSrc),
        .off_i     (bus_q.alu_result[1:0]),
        .ld_type_i (bus_q.ld_type),
        .result_o  (loadData)
    );

    assign finalResult = bus_q.res_from_mem ? loadData : bus_q.alu_result;

    always_comb begin
        wbBus.final_result = finalResult;
        wbBus.gr_we        = bus_q.gr_we;
        wbBus.dest         = bus_q.dest;
        wbBus.pc           = bus_q.pc;
        wbBus.inst         = bus_q.inst;
    end

    assign MEM_to_WB_bus = wbBus;

    // Fields are gated with memValid_q so ID sees an all-zero bus when MEM is empty.
    always_comb begin
        idBus.wr_en        = memValid_q & bus_q.gr_we;
        idBus.dest         = memValid_q ? bus_q.dest : 5'b0;
        idBus.load_pending = memValid_q & bus_q.res_from_mem & ~readyGo;
`ifdef MEM_FWD_EN
        idBus.fwd_data     = idBus.wr_en ? finalResult : 32'b0;
`else
        idBus.fwd_data     = 32'b0;
`endif
    end

    assign MEM_to_ID_bus = idBus;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Directed table of cycles, a hand-written reset-during-load sequence and a
// randomized phase scored against a transaction-level model of the stage.
// Honors MEM_FWD_EN the same way the design does.
module tb_mem_stage;
    import mycpu_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         EX_to_MEM_valid;
    logic [105:0] EX_to_MEM_bus;
    logic         MEM_allow_in;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         WB_allow_in;
    logic         MEM_to_WB_valid;
    logic [101:0] MEM_to_WB_bus;
    logic [38:0]  MEM_to_ID_bus;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .EX_to_MEM_valid   (EX_to_MEM_valid),
        .EX_to_MEM_bus     (EX_to_MEM_bus),
        .MEM_allow_in      (MEM_allow_in),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .WB_allow_in       (WB_allow_in),
        .MEM_to_WB_valid   (MEM_to_WB_valid),
        .MEM_to_WB_bus     (MEM_to_WB_bus),
        .MEM_to_ID_bus     (MEM_to_ID_bus)
    );

    typedef struct {
        logic        exV;
        logic [2:0]  ldt;
        logic        rfm;
        logic [31:0] alu;
        logic        we;
        logic [4:0]  dst;
        logic        dok;
        logic [31:0] rd;
        logic        wba;
        logic        eAllow;
        logic        eWbV;
        logic [31:0] eFinal;
        logic [4:0]  eDest;
        logic        ePend;
        logic        eIdWe;
    } vec_t;

    vec_t vecs[19];
    logic [2:0] codes[5] = '{LD_W, LD_B, LD_H, LD_BU, LD_HU};

    function automatic vec_t mkVec(input logic exV, input logic [2:0] ldt, input logic rfm,
                                   input logic [31:0] alu, input logic we, input logic [4:0] dst,
                                   input logic dok, input logic [31:0] rd, input logic wba,
                                   input logic eAllow, input logic eWbV, input logic [31:0] eFinal,
                                   input logic [4:0] eDest, input logic ePend, input logic eIdWe);
        vec_t v;
        v.exV = exV; v.ldt = ldt; v.rfm = rfm; v.alu = alu; v.we = we; v.dst = dst;
        v.dok = dok; v.rd = rd; v.wba = wba; v.eAllow = eAllow; v.eWbV = eWbV;
        v.eFinal = eFinal; v.eDest = eDest; v.ePend = ePend; v.eIdWe = eIdWe;
        return v;
    endfunction

    function automatic logic [105:0] mkBus(input logic [2:0] ldt, input logic rfm, input logic [31:0] alu,
                                           input logic we, input logic [4:0] dst,
                                           input logic [31:0] pc, input logic [31:0] inst);
        return {ldt, rfm, alu, we, dst, pc, inst};
    endfunction

    // Reference load extraction by shifting and modular arithmetic.
    function automatic logic [31:0] alignRef(input logic [31:0] rd, input int off, input logic [2:0] ldt);
        int unsigned v;
        if (ldt == LD_B || ldt == LD_BU) begin
            v = (rd >> (8 * off)) % 256;
            if (ldt == LD_B && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (ldt == LD_H || ldt == LD_HU) begin
            v = (rd >> (16 * (off / 2))) % 65536;
            if (ldt == LD_H && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic applyStimulus(input logic v, input logic [105:0] bus, input logic dok,
                                 input logic [31:0] rd, input logic wba);
        EX_to_MEM_valid   = v;
        EX_to_MEM_bus     = bus;
        data_sram_data_ok = dok;
        data_sram_rdata   = rd;
        WB_allow_in       = wba;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Transaction-level model: one slot, and whether its load word has already arrived.
    logic         mValid;
    logic         mGot;
    logic [105:0] mBus;
    logic [31:0]  mHeld;

    initial begin
        logic [105:0] bus;
        logic         exV, dok, wba, isLd, we;
        logic [2:0]   ldt;
        logic [31:0]  alu, rd;
        logic [4:0]   dst;
        logic         mIsLd, eReady, eAllow, eWbV;
        logic [31:0]  eData, eFinal;

        vecs[0]  = mkVec(1, LD_W,  0, 32'h0000_1234, 1, 5,  0, 32'h0,         1, 1, 0, 32'h0,         0,  0, 0);
        vecs[1]  = mkVec(1, LD_B,  1, 32'h0000_1003, 1, 7,  0, 32'h0,         1, 1, 1, 32'h0000_1234, 5,  0, 1);
        vecs[2]  = mkVec(1, LD_BU, 1, 32'h0000_1003, 1, 8,  1, 32'h80AA_BBCC, 1, 1, 1, 32'hFFFF_FF80, 7,  0, 1);
        vecs[3]  = mkVec(1, LD_HU, 1, 32'h0000_1002, 1, 9,  1, 32'h80AA_BBCC, 1, 1, 1, 32'h0000_0080, 8,  0, 1);
        vecs[4]  = mkVec(1, LD_W,  0, 32'h0000_0055, 1, 3,  0, 32'h0,         1, 0, 0, 32'h0,         9,  1, 1);
        vecs[5]  = mkVec(1, LD_W,  0, 32'h0000_0055, 1, 3,  0, 32'h0,         1, 0, 0, 32'h0,         9,  1, 1);
        vecs[6]  = mkVec(1, LD_W,  0, 32'h0000_0055, 1, 3,  1, 32'h80AA_BBCC, 1, 1, 1, 32'h0000_80AA, 9,  0, 1);
        vecs[7]  = mkVec(1, LD_W,  1, 32'h0000_2000, 1, 10, 0, 32'h0,         1, 1, 1, 32'h0000_0055, 3,  0, 1);
        vecs[8]  = mkVec(0, LD_W,  0, 32'h0,         0, 0,  1, 32'h1234_5678, 0, 0, 1, 32'h1234_5678, 10, 0, 1);
        vecs[9]  = mkVec(0, LD_W,  0, 32'h0,         0, 0,  0, 32'hDEAD_BEEF, 0, 0, 1, 32'h1234_5678, 10, 0, 1);
        vecs[10] = mkVec(0, LD_W,  0, 32'h0,         0, 0,  1, 32'hDEAD_BEEF, 0, 0, 1, 32'h1234_5678, 10, 0, 1);
        vecs[11] = mkVec(0, LD_W,  0, 32'h0,         0, 0,  0, 32'hDEAD_BEEF, 0, 0, 1, 32'h1234_5678, 10, 0, 1);
        vecs[12] = mkVec(1, LD_W,  1, 32'h0000_3000, 1, 11, 0, 32'hDEAD_BEEF, 1, 1, 1, 32'h1234_5678, 10, 0, 1);
        vecs[13] = mkVec(1, LD_B,  1, 32'h0000_3001, 1, 12, 1, 32'hCAFE_F00D, 1, 1, 1, 32'hCAFE_F00D, 11, 0, 1);
        vecs[14] = mkVec(0, LD_W,  0, 32'h0,         0, 0,  1, 32'hCAFE_F00D, 1, 1, 1, 32'hFFFF_FFF0, 12, 0, 1);
        vecs[15] = mkVec(0, LD_W,  0, 32'h0,         0, 0,  1, 32'h1111_1111, 1, 1, 0, 32'h0,         0,  0, 0);
        vecs[16] = mkVec(1, LD_H,  1, 32'h0000_4000, 1, 13, 0, 32'h0,         1, 1, 0, 32'h0,         0,  0, 0);
        vecs[17] = mkVec(0, LD_W,  0, 32'h0,         0, 0,  0, 32'h0,         1, 0, 0, 32'h0,         13, 1, 1);
        vecs[18] = mkVec(0, LD_W,  0, 32'h0,         0, 0,  1, 32'h0000_8001, 1, 1, 1, 32'hFFFF_8001, 13, 0, 1);

        reset = 1'b1;
        applyStimulus(0, '0, 0, 32'h0, 1);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_allow_in", MEM_allow_in, 1);
        checkOutput("reset_wb_valid", MEM_to_WB_valid, 0);
        checkOutput("reset_id_bus", MEM_to_ID_bus, 0);
        reset = 1'b0;

        $display("[TB] directed table");
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].exV,
                          mkBus(vecs[i].ldt, vecs[i].rfm, vecs[i].alu, vecs[i].we, vecs[i].dst,
                                32'h1C00_0000 + 32'(4 * i), 32'h0280_0000 | 32'(i)),
                          vecs[i].dok, vecs[i].rd, vecs[i].wba);
            #1;
            checkOutput($sformatf("v%0d_allow_in", i), MEM_allow_in, vecs[i].eAllow);
            checkOutput($sformatf("v%0d_wb_valid", i), MEM_to_WB_valid, vecs[i].eWbV);
            if (vecs[i].eWbV) begin
                checkOutput($sformatf("v%0d_final", i), MEM_to_WB_bus[101:70], vecs[i].eFinal);
                checkOutput($sformatf("v%0d_wb_dest", i), MEM_to_WB_bus[68:64], vecs[i].eDest);
            end
            checkOutput($sformatf("v%0d_id_we", i), MEM_to_ID_bus[38], vecs[i].eIdWe);
            checkOutput($sformatf("v%0d_id_pending", i), MEM_to_ID_bus[0], vecs[i].ePend);
            if (vecs[i].eIdWe) begin
                checkOutput($sformatf("v%0d_id_dest", i), MEM_to_ID_bus[37:33], vecs[i].eDest);
            end
`ifdef MEM_FWD_EN
            if (vecs[i].eIdWe && !vecs[i].ePend) begin
                checkOutput($sformatf("v%0d_id_fwd", i), MEM_to_ID_bus[32:1], vecs[i].eFinal);
            end
`else
            checkOutput($sformatf("v%0d_id_fwd", i), MEM_to_ID_bus[32:1], 0);
`endif
        end

        $display("[TB] reset during outstanding load");
        @(negedge clk);
        applyStimulus(1, mkBus(LD_W, 1, 32'h0000_5000, 1, 14, 32'h1C00_1000, 32'h2880_0000), 0, 32'h0, 1);
        #1;
        checkOutput("rst_seq_accept", MEM_allow_in, 1);
        @(negedge clk);
        applyStimulus(0, '0, 0, 32'h0, 1);
        #1;
        checkOutput("rst_seq_pending", MEM_to_ID_bus[0], 1);
        checkOutput("rst_seq_stall", MEM_allow_in, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_mid_wb_valid", MEM_to_WB_valid, 0);
        checkOutput("rst_mid_allow_in", MEM_allow_in, 1);
        checkOutput("rst_mid_id_bus", MEM_to_ID_bus, 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, '0, 1, 32'hABCD_1234, 1);
        #1;
        checkOutput("late_ok_wb_valid", MEM_to_WB_valid, 0);
        checkOutput("late_ok_allow_in", MEM_allow_in, 1);
        checkOutput("late_ok_pending", MEM_to_ID_bus[0], 0);
        @(negedge clk);
        applyStimulus(1, mkBus(LD_W, 0, 32'h0000_0077, 1, 6, 32'h1C00_1004, 32'h0010_0000), 0, 32'h0, 1);
        #1;
        checkOutput("post_rst_wb_valid0", MEM_to_WB_valid, 0);
        @(negedge clk);
        applyStimulus(0, '0, 1, 32'h0000_0099, 1);
        #1;
        checkOutput("post_rst_wb_valid1", MEM_to_WB_valid, 1);
        checkOutput("post_rst_final", MEM_to_WB_bus[101:70], 32'h0000_0077);

        $display("[TB] randomized phase");
        mValid = 1'b0;
        mGot   = 1'b0;
        mBus   = '0;
        mHeld  = 32'h0;
        for (int c = 0; c < 600; c++) begin
            exV  = ($urandom_range(0, 9) < 7);
            isLd = 1'($urandom_range(0, 1));
            ldt  = codes[$urandom_range(0, 4)];
            alu  = $urandom;
            we   = 1'($urandom_range(0, 1));
            dst  = 5'($urandom_range(0, 31));
            bus  = mkBus(ldt, isLd, alu, we, dst, $urandom, $urandom);
            dok  = ($urandom_range(0, 9) < 4);
            rd   = $urandom;
            wba  = ($urandom_range(0, 9) < 7);

            @(negedge clk);
            applyStimulus(exV, bus, dok, rd, wba);
            #1;

            mIsLd  = mBus[102];
            eReady = !mIsLd || mGot || dok;
            eData  = mGot ? mHeld : rd;
            eFinal = mIsLd ? alignRef(eData, int'(mBus[71:70]), mBus[105:103]) : mBus[101:70];
            eAllow = !mValid || (eReady && wba);
            eWbV   = mValid && eReady;

            checkOutput("rnd_allow_in", MEM_allow_in, eAllow);
            checkOutput("rnd_wb_valid", MEM_to_WB_valid, eWbV);
            if (eWbV) begin
                checkOutput("rnd_wb_bus", MEM_to_WB_bus, {eFinal, mBus[69:0]});
            end
            checkOutput("rnd_id_we", MEM_to_ID_bus[38], mValid && mBus[69]);
            checkOutput("rnd_id_pending", MEM_to_ID_bus[0], mValid && mIsLd && !eReady);
            if (mValid) begin
                checkOutput("rnd_id_dest", MEM_to_ID_bus[37:33], mBus[68:64]);
            end
`ifdef MEM_FWD_EN
            if (mValid && mBus[69] && eReady) begin
                checkOutput("rnd_id_fwd", MEM_to_ID_bus[32:1], eFinal);
            end
`else
            checkOutput("rnd_id_fwd", MEM_to_ID_bus[32:1], 0);
`endif

            if (mValid && mIsLd && !mGot && dok && !wba) begin
                mGot  = 1'b1;
                mHeld = rd;
            end
            if (eAllow) begin
                mValid = exV;
                mGot   = 1'b0;
                if (exV) mBus = bus;
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
